crc_checker: RTL and testbench

Serial CRC-8 checker at the receive end of the team's bit-serial CRC link. It consumes a frame of data bits qualified by `ACTIVE`, then the 8 appended CRC bits qualified by `CRC_VALID`, LSB first. It recomputes the CRC over the data with the same LFSR as the generator and compares it bit-by-bit with the received remainder. It reports pass/fail, framing errors and the data length once per frame.

---
 rtl/crc_checker.sv | 173 +++++++++++++++++
 tb/tb_crc_checker.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/crc_checker.sv
// rtl/crc_checker.sv - serial CRC-8 frame checker for the bit-serial CRC link
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   data_i       serial data bit, sampled while active_i=1
//   active_i     data-phase qualifier
//   crc_in_i     serial received CRC bit (LSB first), sampled while crc_valid_i=1
//   crc_valid_i  CRC-phase qualifier
//   done_o       one-cycle pulse when a frame result is available
//   crc_ok_o     frame passed; held until the next frame starts
//   frame_err_o  framing violation; held until the next frame starts
//   data_len_o   saturating data-bit count; live during a frame, held after it
module crc_checker #(
  parameter logic [7:0]  SEED  = 8'hD8,
  parameter logic [7:0]  TABS  = 8'b01000100,
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             data_i,
  input  logic             active_i,
  input  logic             crc_in_i,
  input  logic             crc_valid_i,
  output logic             done_o,
  output logic             crc_ok_o,
  output logic             frame_err_o,
  output logic [LEN_W-1:0] data_len_o
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_GAP, S_CHECK} state_e;

  state_e             state_q, state_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic               mism_q, mism_d;
  logic               done_q, done_d;
  logic               ok_q, ok_d;
  logic               ferr_q, ferr_d;
  logic [LEN_W-1:0]   len_q, len_d;

  // Per-cycle events decoded alongside the next state
  logic start_ev, data_ev, crc_ev, err_ev;

  // One data bit through the generator's LFSR (TABS[7] has no effect: bit 7 takes FB)
  function automatic logic [7:0] lfsr_step(input logic [7:0] l, input logic d);
    logic fb;
    fb = d ^ l[0];
    return {fb, l[7:1] ^ (TABS[6:0] & {7{fb}})};
  endfunction

  // State register and all datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      lfsr_q    <= SEED;
      bit_cnt_q <= '0;
      mism_q    <= 1'b0;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
      ferr_q    <= 1'b0;
      len_q     <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      bit_cnt_q <= bit_cnt_d;
      mism_q    <= mism_d;
      done_q    <= done_d;
      ok_q      <= ok_d;
      ferr_q    <= ferr_d;
      len_q     <= len_d;
    end
  end

  // Next state and event decode
  always_comb begin
    state_d  = state_q;
    start_ev = 1'b0;
    data_ev  = 1'b0;
    crc_ev   = 1'b0;
    err_ev   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // crc_valid_i alone in IDLE is a stray and is ignored
        if (active_i) begin
          start_ev = 1'b1;
          state_d  = S_DATA;
        end
      end
      S_DATA: begin
        if (active_i && crc_valid_i) begin
          err_ev  = 1'b1;
          state_d = S_IDLE;
        end else if (active_i) begin
          data_ev = 1'b1;
        end else if (crc_valid_i) begin
          crc_ev  = 1'b1;
          state_d = S_CHECK;
        end else begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (active_i) begin
          err_ev  = 1'b1;
          state_d = S_IDLE;
        end else if (crc_valid_i) begin
          crc_ev  = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (active_i || !crc_valid_i) begin
          err_ev  = 1'b1;
          state_d = S_IDLE;
        end else begin
          crc_ev = 1'b1;
          if (bit_cnt_q == 3'd7) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    lfsr_d    = lfsr_q;
    bit_cnt_d = bit_cnt_q;
    mism_d    = mism_q;
    done_d    = 1'b0;
    ok_d      = ok_q;
    ferr_d    = ferr_q;
    len_d     = len_q;

    if (start_ev) begin
      lfsr_d    = lfsr_step(SEED, data_i);
      len_d     = LEN_W'(1);
      bit_cnt_d = '0;
      mism_d    = 1'b0;
      ok_d      = 1'b0;
      ferr_d    = 1'b0;
    end

    if (data_ev) begin
      lfsr_d = lfsr_step(lfsr_q, data_i);
      if (len_q != {LEN_W{1'b1}}) len_d = len_q + LEN_W'(1);
    end

    // Remainder leaves LSB first, so compare against lfsr[0] and shift right
    if (crc_ev) begin
      mism_d    = mism_q | (crc_in_i ^ lfsr_q[0]);
      lfsr_d    = {1'b0, lfsr_q[7:1]};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (state_q == S_CHECK && bit_cnt_q == 3'd7) begin
        done_d = 1'b1;
        ok_d   = ~mism_d;
        ferr_d = 1'b0;
      end
    end

    if (err_ev) begin
      done_d = 1'b1;
      ok_d   = 1'b0;
      ferr_d = 1'b1;
    end
  end

  assign done_o      = done_q;
  assign crc_ok_o    = ok_q;
  assign frame_err_o = ferr_q;
  assign data_len_o  = len_q;

endmodule

// File: tb/tb_crc_checker.sv
// tb/tb_crc_checker.sv - scoreboard bench for crc_checker
module tb_crc_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        data, active, crc_in, crc_valid;
  logic        done, crc_ok, frame_err;
  logic [15:0] data_len;

  typedef struct {
    logic        ok;
    logic        ferr;
    logic [15:0] len;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_done = 0;
  int   n_exp_done = 0;

  crc_checker #(
    .SEED (8'hD8),
    .TABS (8'b01000100),
    .LEN_W(16)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .data_i     (data),
    .active_i   (active),
    .crc_in_i   (crc_in),
    .crc_valid_i(crc_valid),
    .done_o     (done),
    .crc_ok_o   (crc_ok),
    .frame_err_o(frame_err),
    .data_len_o (data_len)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference CRC: right shift, then fold FB into bit 7 and the tap positions (0xC4)
  function automatic logic [7:0] crc_model(input logic [15:0] d, input int n);
    logic [7:0] r;
    logic       fb;
    r = 8'hD8;
    for (int i = 0; i < n; i++) begin
      fb = d[i] ^ r[0];
      r  = (r >> 1) ^ (fb ? 8'hC4 : 8'h00);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic ok, input logic ferr, input logic [15:0] len);
    exp_t e;
    e.ok = ok; e.ferr = ferr; e.len = len;
    exp_q.push_back(e);
    last_exp = e;
    n_exp_done++;
  endtask

  // Data bits, idle gap, then ncrc CRC bits; ncrc < 8 ends with an early CRC_VALID drop
  task automatic run_frame(input logic [15:0] d, input int nbits, input logic [7:0] c,
                           input int gap, input int ncrc, input logic exp_ok, input logic exp_ferr);
    for (int i = 0; i < nbits; i++) begin
      active = 1'b1; data = d[i];
      tick();
    end
    active = 1'b0; data = 1'b0;
    repeat (gap) tick();
    for (int i = 0; i < ncrc; i++) begin
      if (i == 7) push_exp(exp_ok, exp_ferr, 16'(nbits));
      crc_valid = 1'b1; crc_in = c[i];
      tick();
    end
    crc_valid = 1'b0; crc_in = 1'b0;
    if (ncrc < 8) begin
      push_exp(exp_ok, exp_ferr, 16'(nbits));
      tick();
    end
    check_eq("done_latency", done, 1'b1);
  endtask

  // Scoreboard: every DONE pops one expected result
  always @(negedge clk) begin
    if (rst_n && done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_done", done, 1'b0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("crc_ok", crc_ok, e.ok);
        check_eq("frame_err", frame_err, e.ferr);
        check_eq("data_len", data_len, e.len);
      end
    end
  end

  initial begin
    logic [7:0] crc_a5;
    crc_a5 = crc_model(16'h00A5, 8);

    rst_n = 1'b0; data = 1'b0; active = 1'b0; crc_in = 1'b0; crc_valid = 1'b0;
    #3;
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_ok", crc_ok, 1'b0);
    check_eq("rst_ferr", frame_err, 1'b0);
    check_eq("rst_len", data_len, 16'd0);
    tick(); tick();
    #3 rst_n = 1'b1;
    tick();

    // Good frame with the generator's one-cycle gap
    run_frame(16'h00A5, 8, crc_a5, 1, 8, 1'b1, 1'b0);
    tick();
    // Corrupt remainder bit 5
    run_frame(16'h00A5, 8, crc_a5 ^ 8'h20, 1, 8, 1'b0, 1'b0);
    tick();
    // CRC_VALID drops after 5 bits
    run_frame(16'h00A5, 8, crc_a5, 1, 5, 1'b0, 1'b1);
    // Back-to-back: starts on the DONE cycle, zero gap, then a 5-cycle gap frame on its DONE
    run_frame(16'h00A5, 8, crc_a5, 0, 8, 1'b1, 1'b0);
    run_frame(16'h00A5, 8, crc_a5, 5, 8, 1'b1, 1'b0);
    // Odd-length frame
    run_frame(16'h1A3C, 13, crc_model(16'h1A3C, 13), 2, 8, 1'b1, 1'b0);

    // ACTIVE during GAP is a framing error and must not start a new frame
    for (int i = 0; i < 8; i++) begin
      active = 1'b1; data = 1'(8'h5A >> i);
      tick();
    end
    active = 1'b0;
    tick(); tick();
    push_exp(1'b0, 1'b1, 16'd8);
    active = 1'b1;
    tick();
    check_eq("gap_err_done", done, 1'b1);
    active = 1'b0;
    tick();

    // Stray CRC_VALID in IDLE: no DONE, outputs held
    for (int i = 0; i < 10; i++) begin
      crc_valid = 1'b1; crc_in = 1'($urandom_range(0, 1));
      tick();
    end
    crc_valid = 1'b0; crc_in = 1'b0;
    tick();
    check_eq("stray_ok", crc_ok, last_exp.ok);
    check_eq("stray_ferr", frame_err, last_exp.ferr);
    check_eq("stray_len", data_len, last_exp.len);

    // Asynchronous reset during CRC bit 3
    for (int i = 0; i < 8; i++) begin
      active = 1'b1; data = 1'(8'hA5 >> i);
      tick();
    end
    active = 1'b0; data = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      crc_valid = 1'b1; crc_in = crc_a5[i];
      tick();
    end
    crc_valid = 1'b1; crc_in = crc_a5[3];
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_done", done, 1'b0);
    check_eq("arst_ok", crc_ok, 1'b0);
    check_eq("arst_ferr", frame_err, 1'b0);
    check_eq("arst_len", data_len, 16'd0);
    crc_valid = 1'b0; crc_in = 1'b0;
    tick(); tick();
    #3 rst_n = 1'b1;
    tick();
    run_frame(16'h00A5, 8, crc_a5, 1, 8, 1'b1, 1'b0);
    tick(); tick();

    check_eq("done_count", n_done, n_exp_done);
    check_eq("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
